// File: rtl/friscv_pack_pkg.sv
// friscv_pack_pkg: shared state encoding and count-width helper for the word packer.
package friscv_pack_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int count_w(input int m);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/demux_1tom_slot_dec.sv
// demux_1tom_slot_dec: S-bit slot index to M-bit one-hot slot write enable.
module demux_1tom_slot_dec #(
    parameter int M = 4,
    parameter int S = 2
) (
    input  logic [S-1:0] idx,
    output logic [M-1:0] sel
);

    for (genvar k = 0; k < M; k++) begin : g_sel
        assign sel[k] = (idx == S'(k));
    end

endmodule

// File: rtl/demux_1tom_pack.sv
// demux_1tom_pack: packs N-bit words into an M-slot vector, valid/ready on both sides.
// Define DEMUX_1TOM_PACK_PASSTHRU_EN to accept a word in HOLD while the vector drains.
module demux_1tom_pack
    import friscv_pack_pkg::*;
#(
    parameter  int N = 8,
    parameter  int M = 4,
    parameter  int S = 2,
    localparam int W = M * N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [S:0]   out_count
);

    state_t         state, state_nxt;
    logic [S-1:0]   idx;
    logic [M-1:0]   sel;
    logic [W-1:0]   data_nxt;
    logic           accept, drain, done;

    demux_1tom_slot_dec #(.M(M), .S(S)) u_dec (
        .idx (idx),
        .sel (sel)
    );

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;
    // idx is always 0 in HOLD, so a pass-through word completes only on in_last or M==1
    assign done   = in_last | (idx == S'(M - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            state    <= state_nxt;
            out_data <= data_nxt;
            if (accept) begin
                idx <= done ? '0 : idx + S'(1);
                if (done) out_count <= (S+1)'(idx) + (S+1)'(1);
            end
        end
    end

    always_comb begin
        state_nxt = (state == HOLD && !drain) ? HOLD : (accept && done) ? HOLD : FILL;
    end

    always_comb begin
        out_valid = (state == HOLD);
`ifdef DEMUX_1TOM_PACK_PASSTHRU_EN
        in_ready  = (state == FILL) | out_ready;
`else
        in_ready  = (state == FILL);
`endif
    end

    // draining clears the vector so unfilled slots of the next one read as zero
    always_comb begin
        data_nxt = drain ? '0 : out_data;
        for (int k = 0; k < M; k++)
            if (accept && sel[k]) data_nxt[N*k +: N] = in_data;
    end

endmodule

// File: tb/tb_demux_1tom_pack.sv
// tb_demux_1tom_pack: directed plus random stimulus against a queue-based packing model.
module tb_demux_1tom_pack;

    localparam int N = 8;
    localparam int M = 4;
    localparam int S = 2;
    localparam int W = M * N;

    typedef struct {
        logic [W-1:0] d;
        logic [S:0]   c;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [S:0]   out_count;

    int           compared = 0;
    int           mism = 0;
    logic [N-1:0] cur[$];
    vec_t         exp_q[$];
    logic         held = 1'b0;
    logic [W-1:0] prev_data;
    logic [S:0]   prev_count;
    logic         acc;
    int           cyc = 0;
    int           vcnt = 0;
    int           rdrop = 0;

    demux_1tom_pack #(.N(N), .M(M), .S(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        assert (got === want)
        else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Called at a negedge with inputs already driven; ends at the next negedge.
    task automatic cycle();
        logic exp_ready;
        vec_t v;
        #1;
`ifdef DEMUX_1TOM_PACK_PASSTHRU_EN
        exp_ready = (exp_q.size() == 0) || out_ready;
`else
        exp_ready = (exp_q.size() == 0);
`endif
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        if (held && exp_q.size() != 0) begin
            chk("hold_data", 64'(out_data), 64'(prev_data));
            chk("hold_count", 64'(out_count), 64'(prev_count));
        end
        if (out_ready && exp_q.size() != 0) begin
            v = exp_q.pop_front();
            chk("out_data", 64'(out_data), 64'(v.d));
            chk("out_count", 64'(out_count), 64'(v.c));
        end
        held       = out_valid && !out_ready;
        prev_data  = out_data;
        prev_count = out_count;
        acc        = in_valid && exp_ready;
        if (acc) begin
            cur.push_back(in_data);
            if (cur.size() == M || in_last) begin
                v.d = '0;
                foreach (cur[i]) v.d[N*i +: N] = cur[i];
                v.c = (S+1)'(cur.size());
                exp_q.push_back(v);
                cur.delete();
            end
        end
        if (out_valid) vcnt++;
        if (!in_ready) rdrop++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [N-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc      = 1'b0;
        while (!acc && n < 50) begin
            cycle();
            n++;
        end
        if (!acc) chk("send_timeout", 64'(n), 64'(0));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) cycle();
    endtask

    task automatic reset_pulse();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        cur.delete();
        exp_q.delete();
        held = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k, t0, t1, n;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset / idle
        reset_pulse();
        idle(2);

        // full vector, out_valid for exactly one cycle
        out_ready = 1'b1;
        vcnt = 0;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        idle(3);
        chk("full_valid_cycles", 64'(vcnt), 64'd1);

        // partial vector then a full one with no stale slots
        send(8'hAA, 0); send(8'hBB, 1);
        idle(2);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        idle(2);

        // backpressure with a word waiting
        out_ready = 1'b0;
        for (int i = 0; i < M; i++) send(N'($urandom), 0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (5) cycle();
        out_ready = 1'b1;
        send(8'h5A, 0);
        for (int i = 0; i < M - 1; i++) send(N'($urandom), 0);
        idle(2);

        // reset mid-fill
        send(8'hE1, 0); send(8'hE2, 0);
        reset_pulse();
        out_ready = 1'b1;
        for (int i = 0; i < M; i++) send(N'($urandom), 0);
        idle(2);

        // continuous flow: cycles from first accept to the 13th accept
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_last = 1'b0;
        k = 0; t0 = 0; t1 = 0; n = 0;
        rdrop = 0;
        while (k < 13 && n < 60) begin
            in_data = N'($urandom);
            cycle();
            n++;
            if (acc) begin
                k++;
                if (k == 1) t0 = cyc;
                if (k == 13) t1 = cyc;
            end
        end
`ifdef DEMUX_1TOM_PACK_PASSTHRU_EN
        chk("stream_cycles", 64'(t1 - t0), 64'd12);
        chk("stream_ready_drops", 64'(rdrop), 64'd0);
`else
        chk("stream_cycles", 64'(t1 - t0), 64'd15);
        chk("stream_ready_drops", 64'(rdrop), 64'd3);
`endif
        idle(1);
        send(8'h00, 1);
        idle(3);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_last   = ($urandom % 5) == 0;
            out_ready = ($urandom % 3) != 0;
            in_data   = N'($urandom);
            cycle();
        end
        in_last = 1'b0;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
